// File: rtl/mem_line_ctrl_if.sv
//------------------------------------------------------------------------------
// mem_line_ctrl_if
// Word-level memory bus between the cache-line controller and a memory
// responder. Signal names are from the controller's point of view.
//   o_read_request      : controller -> memory, read request for o_addr
//   o_write_en          : controller -> memory, write request of o_data to o_addr
//   o_addr              : controller -> memory, word byte address
//   o_data              : controller -> memory, write data
//   i_data              : memory -> controller, read data, valid with access
//   i_successful_access : memory -> controller, current word completes now
//------------------------------------------------------------------------------
interface mem_line_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  o_read_request;
   logic                  o_write_en;
   logic [ADDR_WIDTH-1:0] o_addr;
   logic [DATA_WIDTH-1:0] o_data;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_successful_access;

   modport master (
      output o_read_request,
      output o_write_en,
      output o_addr,
      output o_data,
      input  i_data,
      input  i_successful_access
   );

   modport slave (
      input  o_read_request,
      input  o_write_en,
      input  o_addr,
      input  o_data,
      output i_data,
      output i_successful_access
   );
endinterface

// File: rtl/mem_line_ctrl.sv
//------------------------------------------------------------------------------
// mem_line_ctrl
// Moves one cache line between the cache and a word-wide memory. A one-cycle
// i_start either fills the line from memory (i_we=0) or writes it back
// (i_we=1), one word at a time at line-aligned addresses. Each word waits for
// i_successful_access; a word that waits TIMEOUT cycles aborts the transfer
// with o_error. All outputs are registered.
// Ports:
//   clk          : clock, rising edge
//   arst_n       : synchronous active-low reset
//   i_start      : one-cycle transfer request (accepted only when idle)
//   i_we         : 1 = writeback, 0 = fill; sampled with i_start
//   i_base_addr  : line byte address; sampled with i_start
//   i_wline      : writeback line, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_rline      : filled line, same packing; held between transfers
//   o_busy       : transfer in progress
//   o_done       : one-cycle pulse when a transfer ends (normal or aborted)
//   o_error      : last transfer aborted by timeout
//   mem          : memory bus (see mem_line_ctrl_if)
//------------------------------------------------------------------------------
module mem_line_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int WORDS      = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                        clk,
   input  logic                        arst_n,
   input  logic                        i_start,
   input  logic                        i_we,
   input  logic [ADDR_WIDTH-1:0]       i_base_addr,
   input  logic [WORDS*DATA_WIDTH-1:0] i_wline,
   output logic [WORDS*DATA_WIDTH-1:0] o_rline,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_error,
   mem_line_ctrl_if.master             mem
);
   localparam int IDX_W = $clog2(WORDS);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int HI_W  = ADDR_WIDTH - IDX_W - 2;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                  state;
   logic [IDX_W-1:0]            idx;
   logic [IDX_W-1:0]            idx_inc;
   logic [CNT_W-1:0]            wait_cnt;
   logic [HI_W-1:0]             base_hi;   // line-aligned part of the base
   logic [WORDS*DATA_WIDTH-1:0] wline_q;
   logic                        access;
   logic                        last_word;
   logic                        timed_out;

   assign access    = mem.i_successful_access;
   assign idx_inc   = idx + 1'b1;
   assign last_word = access && (idx == IDX_LAST);
   // The wait counter holds TIMEOUT-1 during the TIMEOUT-th request cycle, so
   // a word with no access aborts after exactly TIMEOUT request cycles.
   assign timed_out = !access && (wait_cnt == CNT_LAST);

   // NOTE: every register here is written with <= so that all of them update
   // from the same pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state              <= S_IDLE;
         idx                <= '0;
         wait_cnt           <= '0;
         base_hi            <= '0;
         wline_q            <= '0;
         // NOTE: the line buffer is plain flops, so it is cleared with
         // everything else; a fill that never ran then reads back as zero.
         o_rline            <= '0;
         o_busy             <= 1'b0;
         o_done             <= 1'b0;
         o_error            <= 1'b0;
         mem.o_read_request <= 1'b0;
         mem.o_write_en     <= 1'b0;
         mem.o_addr         <= '0;
         mem.o_data         <= '0;
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  base_hi            <= i_base_addr[ADDR_WIDTH-1:IDX_W+2];
                  wline_q            <= i_wline;
                  idx                <= '0;
                  wait_cnt           <= '0;
                  o_error            <= 1'b0;
                  o_busy             <= 1'b1;
                  mem.o_addr         <= {i_base_addr[ADDR_WIDTH-1:IDX_W+2], {IDX_W{1'b0}}, 2'b00};
                  mem.o_data         <= i_wline[DATA_WIDTH-1:0];
                  mem.o_read_request <= !i_we;
                  mem.o_write_en     <= i_we;
                  state              <= i_we ? S_WRITE : S_READ;
               end
            end

            S_READ, S_WRITE: begin
               if (access) begin
                  wait_cnt <= '0;
                  if (state == S_READ) begin
                     o_rline[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= mem.i_data;
                  end
                  // Next word is presented in the very next cycle, so the
                  // request never drops between words.
                  if (idx != IDX_LAST) begin
                     idx        <= idx_inc;
                     mem.o_addr <= {base_hi, idx_inc, 2'b00};
                     mem.o_data <= wline_q[int'(idx_inc)*DATA_WIDTH +: DATA_WIDTH];
                  end
               end else if (timed_out) begin
                  o_error <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end

               if (last_word || timed_out) begin
                  state              <= S_DONE;
                  o_busy             <= 1'b0;
                  o_done             <= 1'b1;
                  mem.o_read_request <= 1'b0;
                  mem.o_write_en     <= 1'b0;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
